// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states
// and the datapath mux select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_RTYPE_EX = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_BEQ_EX   = 4'd8;
    localparam logic [3:0] S_ADDI_EX  = 4'd9;
    localparam logic [3:0] S_ADDI_WB  = 4'd10;
    localparam logic [3:0] S_J_EX     = 4'd11;

    typedef enum logic [3:0] {
        ST_FETCH    = S_FETCH,
        ST_DECODE   = S_DECODE,
        ST_MEMADR   = S_MEMADR,
        ST_MEMRD    = S_MEMRD,
        ST_MEMWB    = S_MEMWB,
        ST_MEMWR    = S_MEMWR,
        ST_RTYPE_EX = S_RTYPE_EX,
        ST_RTYPE_WB = S_RTYPE_WB,
        ST_BEQ_EX   = S_BEQ_EX,
        ST_ADDI_EX  = S_ADDI_EX,
        ST_ADDI_WB  = S_ADDI_WB,
        ST_J_EX     = S_J_EX
    } ctrl_state_t;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_timer.sv
// Memory wait counter: counts consecutive not-ready cycles in a memory state
// and flags the last allowed cycle so the FSM can abort to FETCH.
module mem_wait_timer
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] count;

    assign timeout = active && !ready && (count == CW'(MEM_TIMEOUT - 1));

    // Any state change (ready, timeout, or leaving the memory states) clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (active && !ready && !timeout) begin
            count <= count + CW'(1);
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Control FSM sequencing the multicycle MIPS datapath, with memory-ready
// timeout handling and a retired-instruction counter.
//
// state     | meaning
// FETCH     | read inst at PC, PC <= PC+4 when memory is ready
// DECODE    | read regs, precompute branch target, dispatch on opcode
// MEMADR    | ALUOut <= A + sign-ext imm
// MEMRD     | read data memory at ALUOut
// MEMWB     | rt <= MDR
// MEMWR     | write B to data memory at ALUOut
// RTYPE_EX  | ALUOut <= A op B
// RTYPE_WB  | rd <= ALUOut
// BEQ_EX    | compare A, B; PC <= target if equal
// ADDI_EX   | ALUOut <= A + sign-ext imm
// ADDI_WB   | rt <= ALUOut
// J_EX      | PC <= {PC[31:28], inst[25:0], 2'b00}
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Jump,
    output logic             illegal_op,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        is_store;
    logic        mem_active;
    logic        timeout;
    logic        retire;
    logic        illegal_next;
    logic        err_next;

    // zero only steers the PC through PCWriteCond in the datapath
    logic zero_unused;
    assign zero_unused = zero;

    assign mem_active = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .active (mem_active),
        .ready  (mem_ready),
        .timeout(timeout)
    );

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        PCSource    = PCSRC_ALU;
        case (state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            ST_DECODE:   ALUSrcB = SRCB_IMM_SH;
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_RTYPE_EX: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            ST_RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_BEQ_EX: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            ST_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_ADDI_WB:  RegWrite = 1'b1;
            ST_J_EX: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign Jump = (PCSource == PCSRC_JUMP);

    always_comb begin
        state_next   = state;
        retire       = 1'b0;
        illegal_next = 1'b0;
        err_next     = 1'b0;
        case (state)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    state_next = ST_FETCH;
                    err_next   = 1'b1;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_next = ST_RTYPE_EX;
                    OP_LW, OP_SW:  state_next = ST_MEMADR;
                    OP_BEQ:        state_next = ST_BEQ_EX;
                    OP_ADDI:       state_next = ST_ADDI_EX;
                    OP_J:          state_next = ST_J_EX;
                    default: begin
                        state_next   = ST_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            ST_MEMADR:   state_next = is_store ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD: begin
                if (mem_ready) begin
                    state_next = ST_MEMWB;
                end else if (timeout) begin
                    state_next = ST_FETCH;
                    err_next   = 1'b1;
                end
            end
            ST_MEMWR: begin
                if (mem_ready) begin
                    state_next = ST_FETCH;
                    retire     = 1'b1;
                end else if (timeout) begin
                    state_next = ST_FETCH;
                    err_next   = 1'b1;
                end
            end
            ST_RTYPE_EX: state_next = ST_RTYPE_WB;
            ST_ADDI_EX:  state_next = ST_ADDI_WB;
            ST_MEMWB, ST_RTYPE_WB, ST_BEQ_EX, ST_ADDI_WB, ST_J_EX: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            default:     state_next = ST_FETCH;
        endcase
    end

    // The lw/sw choice is latched in DECODE because opcode is only valid there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_FETCH;
            is_store   <= 1'b0;
            illegal_op <= 1'b0;
            mem_err    <= 1'b0;
            retired    <= '0;
        end else begin
            state      <= state_next;
            illegal_op <= illegal_next;
            mem_err    <= err_next;
            if (state == ST_DECODE) begin
                is_store <= (opcode == OP_SW);
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule
